// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one 8-bit ALU between two requesters. Arbitrates with
//               a valid/ready handshake, latches the winner's operands, runs
//               the ALU from those latched copies, and returns the registered
//               result and flags on a single backpressured response channel.
//               Keeps a saturating accept counter per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rq0_valid,
    output logic             rq0_ready,
    input  logic [7:0]       rq0_a,
    input  logic [7:0]       rq0_b,
    input  logic [2:0]       rq0_op,
    input  logic             rq1_valid,
    output logic             rq1_ready,
    input  logic [7:0]       rq1_a,
    input  logic [7:0]       rq1_b,
    input  logic [2:0]       rq1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_cout,
    output logic             rsp_ov,
    output logic             rsp_neg,
    output logic             rsp_zero,
    output logic             rsp_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [2:0]       r_op;
    logic             r_id;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_cout;
    logic             r_rsp_ov;
    logic             r_rsp_neg;
    logic             r_rsp_zero;
    logic             r_rsp_id;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_idle;
    logic             w_both_pick;
    logic             w_grant;
    logic             w_accept;
    logic [8:0]       w_sum;
    logic [7:0]       w_alu_out;
    logic             w_alu_cout;
    logic             w_alu_ov;
    logic             w_alu_neg;
    logic             w_alu_zero;

    assign w_idle = (r_state == ST_IDLE);

    // Winner when both requesters contend: alternate, or always requester 0.
    generate
        if (RR_EN != 0) begin : g_round_robin
            assign w_both_pick = ~r_last_grant;
        end else begin : g_fixed_priority
            assign w_both_pick = 1'b0;
        end
    endgenerate

    // Combinational grant; a lone requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (rq0_valid && rq1_valid) begin
            w_grant = w_both_pick;
        end else if (rq1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign rq0_ready = w_idle & ~w_grant & rq0_valid;
    assign rq1_ready = w_idle &  w_grant & rq1_valid;
    assign w_accept  = rq0_ready | rq1_ready;

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (r_rsp_valid && rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shared ALU, fed only from the latched operands so late changes on the
    // request inputs cannot disturb an in-flight operation.
    always_comb begin
        w_sum      = 9'd0;
        w_alu_out  = 8'd0;
        w_alu_cout = 1'b0;
        w_alu_ov   = 1'b0;
        case (r_op)
            3'b000: begin
                w_sum      = {1'b0, r_a} + {1'b0, r_b};
                w_alu_out  = w_sum[7:0];
                w_alu_cout = w_sum[8];
                w_alu_ov   = (r_a[7] == r_b[7]) && (w_alu_out[7] != r_a[7]);
            end
            3'b001: begin
                // Two's-complement subtract: carry-out high means no borrow.
                w_sum      = {1'b0, r_a} + {1'b0, ~r_b} + 9'd1;
                w_alu_out  = w_sum[7:0];
                w_alu_cout = w_sum[8];
                w_alu_ov   = (r_a[7] != r_b[7]) && (w_alu_out[7] != r_a[7]);
            end
            3'b010: begin
                w_sum      = {1'b0, r_a} + 9'd1;
                w_alu_out  = w_sum[7:0];
                w_alu_cout = w_sum[8];
                w_alu_ov   = (r_a == 8'h7F);
            end
            3'b011:  w_alu_out = r_a;
            3'b100:  w_alu_out = r_a & r_b;
            3'b101:  w_alu_out = r_a | r_b;
            3'b110:  w_alu_out = r_a ^ r_b;
            default: w_alu_out = ~r_a;
        endcase
        w_alu_neg  = w_alu_out[7];
        w_alu_zero = (w_alu_out == 8'd0);
    end

    // Operand capture, response registers and grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_a          <= 8'd0;
            r_b          <= 8'd0;
            r_op         <= 3'd0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 8'd0;
            r_rsp_cout   <= 1'b0;
            r_rsp_ov     <= 1'b0;
            r_rsp_neg    <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant ? rq1_a  : rq0_a;
                        r_b          <= w_grant ? rq1_b  : rq0_b;
                        r_op         <= w_grant ? rq1_op : rq0_op;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        if (!w_grant && (r_cnt0 != C_CNT_MAX)) r_cnt0 <= r_cnt0 + C_CNT_ONE;
                        if (w_grant && (r_cnt1 != C_CNT_MAX))  r_cnt1 <= r_cnt1 + C_CNT_ONE;
                    end
                end
                ST_EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_alu_out;
                    r_rsp_cout  <= w_alu_cout;
                    r_rsp_ov    <= w_alu_ov;
                    r_rsp_neg   <= w_alu_neg;
                    r_rsp_zero  <= w_alu_zero;
                    r_rsp_id    <= r_id;
                end
                ST_RESP: begin
                    // Data and flags are left untouched after the handshake.
                    if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_ov    = r_rsp_ov;
    assign rsp_neg   = r_rsp_neg;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_id    = r_rsp_id;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;
    assign busy      = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Three instances cover
//               round-robin, fixed priority and a 2-bit counter. Expected
//               grants, results and counts come from a transaction-level
//               model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus and observation (0: RR, 1: fixed, 2: CNT_W=2).
    logic       v0 [3];
    logic       v1 [3];
    logic       rr [3];
    logic [7:0] a0 [3];
    logic [7:0] b0 [3];
    logic [2:0] o0 [3];
    logic [7:0] a1 [3];
    logic [7:0] b1 [3];
    logic [2:0] o1 [3];
    logic       y0 [3];
    logic       y1 [3];
    logic       rv [3];
    logic [7:0] rd [3];
    logic       rc [3];
    logic       ro [3];
    logic       rn [3];
    logic       rz [3];
    logic       ri [3];
    logic       bz [3];
    logic [15:0] c0w [2];
    logic [15:0] c1w [2];
    logic [1:0]  c0n;
    logic [1:0]  c1n;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_last [3];
    int m_cnt0 [3];
    int m_cnt1 [3];
    int rr_en  [3] = '{1, 0, 1};
    int cmax   [3] = '{65535, 65535, 3};

    alu_arbiter #(.RR_EN(1), .CNT_W(16)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(v0[0]), .rq0_ready(y0[0]), .rq0_a(a0[0]), .rq0_b(b0[0]), .rq0_op(o0[0]),
        .rq1_valid(v1[0]), .rq1_ready(y1[0]), .rq1_a(a1[0]), .rq1_b(b1[0]), .rq1_op(o1[0]),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_data(rd[0]), .rsp_cout(rc[0]),
        .rsp_ov(ro[0]), .rsp_neg(rn[0]), .rsp_zero(rz[0]), .rsp_id(ri[0]),
        .cnt0(c0w[0]), .cnt1(c1w[0]), .busy(bz[0])
    );

    alu_arbiter #(.RR_EN(0), .CNT_W(16)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(v0[1]), .rq0_ready(y0[1]), .rq0_a(a0[1]), .rq0_b(b0[1]), .rq0_op(o0[1]),
        .rq1_valid(v1[1]), .rq1_ready(y1[1]), .rq1_a(a1[1]), .rq1_b(b1[1]), .rq1_op(o1[1]),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_data(rd[1]), .rsp_cout(rc[1]),
        .rsp_ov(ro[1]), .rsp_neg(rn[1]), .rsp_zero(rz[1]), .rsp_id(ri[1]),
        .cnt0(c0w[1]), .cnt1(c1w[1]), .busy(bz[1])
    );

    alu_arbiter #(.RR_EN(1), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(v0[2]), .rq0_ready(y0[2]), .rq0_a(a0[2]), .rq0_b(b0[2]), .rq0_op(o0[2]),
        .rq1_valid(v1[2]), .rq1_ready(y1[2]), .rq1_a(a1[2]), .rq1_b(b1[2]), .rq1_op(o1[2]),
        .rsp_valid(rv[2]), .rsp_ready(rr[2]), .rsp_data(rd[2]), .rsp_cout(rc[2]),
        .rsp_ov(ro[2]), .rsp_neg(rn[2]), .rsp_zero(rz[2]), .rsp_id(ri[2]),
        .cnt0(c0n), .cnt1(c1n), .busy(bz[2])
    );

    function automatic int cnt_of(input int k, input int which);
        if (k == 2) return (which != 0) ? int'(c1n) : int'(c0n);
        return (which != 0) ? int'(c1w[k]) : int'(c0w[k]);
    endfunction

    // Arithmetic reference: returns {cout, ov, neg, zero, data}.
    function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        logic [7:0] d;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        r = 0; sr = 0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; sr = sa + sb; c = (r > 255); v = (sr > 127) || (sr < -128); end
            3'd1: begin r = ua - ub; sr = sa - sb; c = (ua >= ub); v = (sr > 127) || (sr < -128); end
            3'd2: begin r = ua + 1; c = (ua == 255); v = (sa == 127); end
            3'd3: r = ua;
            3'd4: r = ua & ub;
            3'd5: r = ua | ub;
            3'd6: r = ua ^ ub;
            default: r = 255 - ua;
        endcase
        d = r[7:0];
        return {c, v, d[7], (d == 8'd0), d};
    endfunction

    // One complete transaction on instance k; entered and left at a negedge.
    task automatic run_txn(input int k, input logic lv0, input logic lv1,
                           input logic [7:0] la0, input logic [7:0] lb0, input logic [2:0] lo0,
                           input logic [7:0] la1, input logic [7:0] lb1, input logic [2:0] lo1,
                           input int hold);
        int g, e0, e1;
        logic [11:0] e;
        v0[k] = lv0; v1[k] = lv1;
        a0[k] = la0; b0[k] = lb0; o0[k] = lo0;
        a1[k] = la1; b1[k] = lb1; o1[k] = lo1;
        rr[k] = (hold == 0);
        #1;
        if (lv0 && lv1) g = (rr_en[k] != 0) ? 1 - m_last[k] : 0;
        else            g = lv0 ? 0 : 1;
        e = (g == 0) ? ref_alu(la0, lb0, lo0) : ref_alu(la1, lb1, lo1);
        total++;
        if ({bz[k], y1[k], y0[k]} !== {1'b0, (g == 1), (g == 0)}) begin
            bad++;
            $display("FAIL grant inst%0d: busy/rdy1/rdy0 got %b%b%b want 0%b%b",
                     k, bz[k], y1[k], y0[k], (g == 1), (g == 0));
        end
        @(posedge clk);
        m_last[k] = g;
        if (g == 0) m_cnt0[k]++; else m_cnt1[k]++;
        @(negedge clk);
        total++;
        if ({rv[k], bz[k], y1[k], y0[k]} !== 4'b0100) begin
            bad++;
            $display("FAIL exec inst%0d: valid/busy/rdy1/rdy0 got %b%b%b%b want 0100",
                     k, rv[k], bz[k], y1[k], y0[k]);
        end
        // Disturb the request inputs: the in-flight result must not change.
        a0[k] = 8'($urandom); b0[k] = 8'($urandom); o0[k] = 3'($urandom);
        a1[k] = 8'($urandom); b1[k] = 8'($urandom); o1[k] = 3'($urandom);
        @(negedge clk);
        e0 = (m_cnt0[k] > cmax[k]) ? cmax[k] : m_cnt0[k];
        e1 = (m_cnt1[k] > cmax[k]) ? cmax[k] : m_cnt1[k];
        total++;
        if ({rv[k], ri[k], rc[k], ro[k], rn[k], rz[k], rd[k]} !== {1'b1, (g == 1), e}) begin
            bad++;
            $display("FAIL response inst%0d: valid/id/c/v/n/z/data got %b %b %b%b%b%b %h want 1 %b %b %h",
                     k, rv[k], ri[k], rc[k], ro[k], rn[k], rz[k], rd[k], (g == 1), e[11:8], e[7:0]);
        end
        total++;
        if ((cnt_of(k, 0) != e0) || (cnt_of(k, 1) != e1)) begin
            bad++;
            $display("FAIL counters inst%0d: got %0d/%0d want %0d/%0d",
                     k, cnt_of(k, 0), cnt_of(k, 1), e0, e1);
        end
        repeat (hold) begin
            @(negedge clk);
            total++;
            if ({rv[k], bz[k], y1[k], y0[k], ri[k], rc[k], ro[k], rn[k], rz[k], rd[k]} !==
                {4'b1100, (g == 1), e}) begin
                bad++;
                $display("FAIL backpressure inst%0d: valid/busy/rdy1/rdy0 %b%b%b%b id %b flags %b%b%b%b data %h want 1100 %b %h",
                         k, rv[k], bz[k], y1[k], y0[k], ri[k], rc[k], ro[k], rn[k], rz[k], rd[k], (g == 1), e);
            end
        end
        rr[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({rv[k], bz[k], rd[k]} !== {2'b00, e[7:0]}) begin
            bad++;
            $display("FAIL handshake inst%0d: valid/busy %b%b data %h want 00 %h",
                     k, rv[k], bz[k], rd[k], e[7:0]);
        end
        v0[k] = 1'b0; v1[k] = 1'b0; rr[k] = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_last[k] = 1; m_cnt0[k] = 0; m_cnt1[k] = 0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            v0[k] = 1'b0; v1[k] = 1'b0; rr[k] = 1'b0;
            a0[k] = 8'd0; b0[k] = 8'd0; o0[k] = 3'd0;
            a1[k] = 8'd0; b1[k] = 8'd0; o1[k] = 3'd0;
        end
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({rv[k], rd[k], rc[k], ro[k], rn[k], rz[k], ri[k], bz[k], y0[k], y1[k]} !== 17'd0 ||
                cnt_of(k, 0) != 0 || cnt_of(k, 1) != 0) begin
                bad++;
                $display("FAIL reset inst%0d: valid %b data %h flags %b%b%b%b id %b busy %b rdy %b%b cnt %0d/%0d want all 0",
                         k, rv[k], rd[k], rc[k], ro[k], rn[k], rz[k], ri[k], bz[k], y0[k], y1[k],
                         cnt_of(k, 0), cnt_of(k, 1));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        run_txn(0, 1'b1, 1'b0, 8'h7F, 8'h01, 3'd0, 8'h00, 8'h00, 3'd0, 0);
        total++;
        if ({rd[0], rc[0], ro[0], rn[0], rz[0], ri[0]} !== {8'h80, 5'b01100} || c0w[0] !== 16'd1) begin
            bad++;
            $display("FAIL single_op: data %h c/v/n/z %b%b%b%b id %b cnt0 %0d want 80 0110 0 1",
                     rd[0], rc[0], ro[0], rn[0], rz[0], ri[0], c0w[0]);
        end
    endtask

    task automatic test_simultaneous();
        test_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(0, 1'b1, 1'b1, 8'd5, 8'd5, 3'd1, 8'h00, 8'h00, 3'd7, 0);
            total++;
            if ((i % 2) == 0) begin
                if ({ri[0], rd[0], rc[0], ro[0], rn[0], rz[0]} !== {1'b0, 8'h00, 4'b1001}) begin
                    bad++;
                    $display("FAIL simultaneous[%0d]: id %b data %h c/v/n/z %b%b%b%b want 0 00 1001",
                             i, ri[0], rd[0], rc[0], ro[0], rn[0], rz[0]);
                end
            end else begin
                if ({ri[0], rd[0], rc[0], ro[0], rn[0], rz[0]} !== {1'b1, 8'hFF, 4'b0010}) begin
                    bad++;
                    $display("FAIL simultaneous[%0d]: id %b data %h c/v/n/z %b%b%b%b want 1 ff 0010",
                             i, ri[0], rd[0], rc[0], ro[0], rn[0], rz[0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        run_txn(0, 1'b1, 1'b1, 8'h3C, 8'h0F, 3'd4, 8'h10, 8'h20, 3'd0, 5);
        run_txn(0, 1'b1, 1'b1, 8'h01, 8'h02, 3'd5, 8'h90, 8'h90, 3'd0, 5);
    endtask

    task automatic test_fixed_priority();
        for (int i = 0; i < 6; i++) begin
            run_txn(1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom),
                    8'($urandom), 8'($urandom), 3'($urandom), i % 2);
            total++;
            if (ri[1] !== 1'b0) begin
                bad++;
                $display("FAIL fixed_id[%0d]: got %b want 0", i, ri[1]);
            end
        end
        total++;
        if (c0w[1] !== 16'd6 || c1w[1] !== 16'd0) begin
            bad++;
            $display("FAIL fixed_cnt: got %0d/%0d want 6/0", c0w[1], c1w[1]);
        end
    endtask

    task automatic test_reset_mid_op();
        v0[0] = 1'b1; a0[0] = 8'h11; b0[0] = 8'h22; o0[0] = 3'd0; rr[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        v0[0] = 1'b0;
        model_reset();
        #1;
        total++;
        if ({rv[0], bz[0]} !== 2'b00 || c0w[0] !== 16'd0 || c1w[0] !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_op: valid %b busy %b cnt %0d/%0d want 0 0 0/0",
                     rv[0], bz[0], c0w[0], c1w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({rv[0], bz[0]} !== 2'b00) begin
                bad++;
                $display("FAIL dropped_txn: valid %b busy %b want 00", rv[0], bz[0]);
            end
        end
        rr[0] = 1'b0;
        run_txn(0, 1'b1, 1'b1, 8'h40, 8'h40, 3'd0, 8'h01, 8'h01, 3'd6, 0);
        total++;
        if (ri[0] !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_grant: id %b want 0", ri[0]);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            run_txn(2, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 8'h7F, 8'h00, 3'd2, 0);
            total++;
            if (rd[2] !== 8'h80 || ro[2] !== 1'b1 || c1n !== ((i >= 2) ? 2'd3 : 2'(i + 1))) begin
                bad++;
                $display("FAIL saturation[%0d]: data %h ov %b cnt1 %0d want 80 1 %0d",
                         i, rd[2], ro[2], c1n, (i >= 2) ? 3 : i + 1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int sel;
            int k;
            k = i % 2;
            sel = 1 + int'($urandom_range(2, 0));
            run_txn(k, sel[0], sel[1], 8'($urandom), 8'($urandom), 3'($urandom),
                    8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(3, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_simultaneous();
        test_backpressure();
        test_fixed_priority();
        test_saturation();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
